data_sram_bridge: RTL and testbench
===================================

DATA_SRAM_BRIDGE -- requirements
Module: data_sram_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the physical address width.
REQ-002 SHALL have the following ports, with clock and reset first:
- clk  in  1  system clock.
- resetn  in  1  reset, asynchronous, active-low.
- sram_data_ena  in  1  upstream memory request valid.
- sram_data_wen  in  4  byte write enables; nonzero means store.
- sram_load_type  in  4  load type: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU; any other value is treated as LW.
- sram_uncached  in  1  uncached attribute.
- sram_data_vaddr  in  32  virtual address; used only for trace, not used by this block.
- sram_data_psyaddr  in  ADDR_W  physical address.
- sram_data_wdata  in  32  store data, already lane-aligned.
- flush  in  1  exception/cancel from the writeback stage.
- sram_data_rdata  out  32  extended load result.
- data_stall  out  1  upstream must hold its request.
- bus_req  out  1  bus request valid.
- bus_wr  out  1  1 = write.
- bus_size  out  2  0 byte, 1 half, 2 word.
- bus_addr  out  ADDR_W  bus address.
- bus_wstrb  out  4  write strobes.
- bus_wdata  out  32  write data.
- bus_uncached  out  1  uncached attribute.
- bus_addr_ok  in  1  request accepted.
- bus_data_ok  in  1  transfer complete / rdata valid.
- bus_rdata  in  32  read data.

Function
REQ-003 SHALL implement FSM states IDLE, ADDR and DATA, one-hot or binary encoded.
REQ-004 IDLE: when sram_data_ena=1 and flush=0, SHALL latch wen, load_type, uncached, psyaddr and wdata into request registers and go to ADDR at the next edge.
REQ-005 IDLE: when flush=1, SHALL accept nothing and stay in IDLE.
REQ-006 ADDR: SHALL hold bus_req=1 with all bus_* outputs driven from the request registers and stable; on bus_addr_ok=1 SHALL go to DATA and drop bus_req at the same edge.
REQ-007 DATA: SHALL hold bus_req=0; on bus_data_ok=1 SHALL return to IDLE.
REQ-008 DATA: bus_data_ok SHALL be ignored in every state other than DATA; the bus never asserts data_ok in the same cycle as addr_ok.
REQ-009 flush SHALL be ignored in ADDR and DATA; an issued transaction always runs to completion.
REQ-010 data_stall SHALL equal (IDLE & sram_data_ena & ~flush) | ADDR | (DATA & ~bus_data_ok), computed combinationally.
REQ-011 Minimum request-to-release latency SHALL be 3 cycles: accept in IDLE, addr_ok in ADDR, data_ok in DATA.
REQ-012 Store size SHALL be taken from the latched wen:
- popcount 1 -> size 0.
- wen 0011 or 1100 -> size 1.
- any other nonzero wen -> size 2.
- bus_wstrb SHALL equal wen.
- bus_addr SHALL equal psyaddr with the low 2 bits kept.
REQ-013 Load size SHALL be 0 for LB/LBU, 1 for LH/LHU and 2 otherwise; bus_wstrb SHALL be 0 for loads.
REQ-014 On a load with bus_data_ok in DATA, sram_data_rdata SHALL register the extended result at that edge:
- Select the byte lane from psyaddr[1:0] and the half lane from psyaddr[1].
- LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
REQ-015 sram_data_rdata SHALL hold its value until the next load completes; stores SHALL NOT modify it.
REQ-016 Misaligned addresses are filtered upstream; this block SHALL NOT check alignment.
REQ-017 The request registers SHALL be loaded only in IDLE, so upstream changes while stalled have no effect.

Reset
REQ-018 When resetn=0 the FSM SHALL go to IDLE asynchronously.
REQ-019 When resetn=0, bus_req, bus_wr, bus_size, bus_addr, bus_wstrb, bus_wdata, bus_uncached, sram_data_rdata and all request registers SHALL be 0.
REQ-020 Reset asserted in ADDR or DATA SHALL abandon the transaction; after release, bus_data_ok SHALL be ignored until a new request reaches DATA.
REQ-021 data_stall SHALL follow REQ-010 from IDLE immediately after reset release.

Verification
REQ-022 LB at psyaddr 0x1FC00003; bus_rdata=0x80FF_FF7F, addr_ok and data_ok each one cycle after request -> bus_size=0, bus_addr=0x1FC00003, sram_data_rdata=0xFFFFFF80, data_stall high for exactly 2 cycles.
REQ-023 LHU at psyaddr 0x00000002, bus_rdata=0x8001_1234 -> bus_size=1, sram_data_rdata=0x00008001.
REQ-024 SW, wen=1111, wdata=0xDEADBEEF, addr_ok delayed 4 cycles -> bus_req held 4 cycles with stable fields, bus_wr=1, bus_size=2, bus_wstrb=1111, sram_data_rdata unchanged.
REQ-025 flush=1 with sram_data_ena=1 in IDLE -> no bus_req and data_stall=0; flush=1 in ADDR -> the transaction still completes.
REQ-026 resetn pulsed low while in DATA -> IDLE and all outputs 0 immediately; a stray bus_data_ok after release -> no state change and rdata stays 0.
REQ-027 Back-to-back loads with sram_data_ena held high -> the second request is accepted in the IDLE cycle right after the first data_ok, and no cycle is lost beyond REQ-011.

Source files
------------

// File: rtl/data_sram_bridge.sv
// Data-side SRAM-style to addr_ok/data_ok bus bridge.
// Single outstanding request; load results extended here.
module data_sram_bridge #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              sram_data_ena,
  input  logic [3:0]        sram_data_wen,
  input  logic [3:0]        sram_load_type,
  input  logic              sram_uncached,
  input  logic [31:0]       sram_data_vaddr,
  input  logic [ADDR_W-1:0] sram_data_psyaddr,
  input  logic [31:0]       sram_data_wdata,
  input  logic              flush,
  output logic [31:0]       sram_data_rdata,
  output logic              data_stall,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_wstrb,
  output logic [31:0]       bus_wdata,
  output logic              bus_uncached,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [31:0]       bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [3:0] LT_LB  = 4'd1;
  localparam logic [3:0] LT_LBU = 4'd2;
  localparam logic [3:0] LT_LH  = 4'd3;
  localparam logic [3:0] LT_LHU = 4'd4;

  state_t            state;
  logic [3:0]        wen_q;
  logic [3:0]        lt_q;
  logic              unc_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        size_q;
  logic              req_q;
  logic              wr_q;
  logic [31:0]       rdata_q;

  logic              accept;
  logic [1:0]        next_size;
  logic [7:0]        byte_lane;
  logic [15:0]       half_lane;
  logic [31:0]       ext_data;

  // vaddr is trace-only
  logic unused_ok;
  assign unused_ok = ^sram_data_vaddr;

  function automatic logic [1:0] st_size(input logic [3:0] wen);
    logic [1:0] s;
    unique case (wen)
      4'b0001, 4'b0010,
      4'b0100, 4'b1000: s = 2'd0;
      4'b0011, 4'b1100: s = 2'd1;
      default:          s = 2'd2;
    endcase
    return s;
  endfunction

  function automatic logic [1:0] ld_size(input logic [3:0] lt);
    logic [1:0] s;
    unique case (lt)
      LT_LB, LT_LBU: s = 2'd0;
      LT_LH, LT_LHU: s = 2'd1;
      default:       s = 2'd2;
    endcase
    return s;
  endfunction

  assign accept = (state == IDLE) & sram_data_ena & ~flush;

  assign next_size = (|sram_data_wen) ? st_size(sram_data_wen)
                                      : ld_size(sram_load_type);

  always_comb begin
    byte_lane = bus_rdata[7:0];
    unique case (addr_q[1:0])
      2'd0: byte_lane = bus_rdata[7:0];
      2'd1: byte_lane = bus_rdata[15:8];
      2'd2: byte_lane = bus_rdata[23:16];
      2'd3: byte_lane = bus_rdata[31:24];
      default: byte_lane = bus_rdata[7:0];
    endcase
  end

  assign half_lane = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

  always_comb begin
    ext_data = bus_rdata;
    unique case (lt_q)
      LT_LB:   ext_data = {{24{byte_lane[7]}}, byte_lane};
      LT_LBU:  ext_data = {24'd0, byte_lane};
      LT_LH:   ext_data = {{16{half_lane[15]}}, half_lane};
      LT_LHU:  ext_data = {16'd0, half_lane};
      default: ext_data = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      wen_q   <= '0;
      lt_q    <= '0;
      unc_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            wen_q   <= sram_data_wen;
            lt_q    <= sram_load_type;
            unc_q   <= sram_uncached;
            addr_q  <= sram_data_psyaddr;
            wdata_q <= sram_data_wdata;
            size_q  <= next_size;
            wr_q    <= |sram_data_wen;
            req_q   <= 1'b1;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (bus_addr_ok) begin
            req_q <= 1'b0;
            state <= DATA;
          end
        end
        DATA: begin
          if (bus_data_ok) begin
            state <= IDLE;
            if (!wr_q) rdata_q <= ext_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign data_stall = accept
                    | (state == ADDR)
                    | ((state == DATA) & ~bus_data_ok);

  assign bus_req         = req_q;
  assign bus_wr          = wr_q;
  assign bus_size        = size_q;
  assign bus_addr        = addr_q;
  assign bus_wstrb       = wen_q;
  assign bus_wdata       = wdata_q;
  assign bus_uncached    = unc_q;
  assign sram_data_rdata = rdata_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed bench for data_sram_bridge.
// Vector table plus hand-written reset/flush/back-to-back sequences.
module tb_data_sram_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ena;
  logic [3:0]  wen;
  logic [3:0]  lt;
  logic        unc;
  logic [31:0] vaddr;
  logic [31:0] psy;
  logic [31:0] wdata;
  logic        flush;
  logic [31:0] rdata;
  logic        stall;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_unc;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] brdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_sram_bridge #(.ADDR_W(32)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .sram_data_ena    (ena),
    .sram_data_wen    (wen),
    .sram_load_type   (lt),
    .sram_uncached    (unc),
    .sram_data_vaddr  (vaddr),
    .sram_data_psyaddr(psy),
    .sram_data_wdata  (wdata),
    .flush            (flush),
    .sram_data_rdata  (rdata),
    .data_stall       (stall),
    .bus_req          (bus_req),
    .bus_wr           (bus_wr),
    .bus_size         (bus_size),
    .bus_addr         (bus_addr),
    .bus_wstrb        (bus_wstrb),
    .bus_wdata        (bus_wdata),
    .bus_uncached     (bus_unc),
    .bus_addr_ok      (addr_ok),
    .bus_data_ok      (data_ok),
    .bus_rdata        (brdata)
  );

  typedef struct {
    logic [3:0]  wen;
    logic [3:0]  lt;
    logic        unc;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] brdata;
    int          adly;
    int          ddly;
    logic [1:0]  size;
    logic [31:0] rdata;
  } vec_t;

  vec_t v[12];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req"}, 32'(bus_req), 32'd0);
    chk({tag, "_wr"}, 32'(bus_wr), 32'd0);
    chk({tag, "_size"}, 32'(bus_size), 32'd0);
    chk({tag, "_addr"}, bus_addr, 32'd0);
    chk({tag, "_wstrb"}, 32'(bus_wstrb), 32'd0);
    chk({tag, "_wdata"}, bus_wdata, 32'd0);
    chk({tag, "_unc"}, 32'(bus_unc), 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
  endtask

  task automatic run(input vec_t t, input logic flush_mid);
    int scnt;
    scnt = 0;
    @(negedge clk);
    ena = 1'b1; wen = t.wen; lt = t.lt; unc = t.unc;
    psy = t.addr; wdata = t.wdata; flush = 1'b0;
    #1 if (stall) scnt++;
    @(negedge clk);
    // scramble upstream while stalled; latched fields must not move
    ena = 1'b0; psy = ~t.addr; wdata = ~t.wdata;
    wen = ~t.wen; lt = ~t.lt; unc = ~t.unc; flush = flush_mid;
    for (int i = 0; i <= t.adly; i++) begin
      addr_ok = (i == t.adly);
      #1;
      chk("addr_req", 32'(bus_req), 32'd1);
      chk("addr_wr", 32'(bus_wr), 32'(|t.wen));
      chk("addr_size", 32'(bus_size), 32'(t.size));
      chk("addr_addr", bus_addr, t.addr);
      chk("addr_wstrb", 32'(bus_wstrb), 32'(t.wen));
      chk("addr_wdata", bus_wdata, t.wdata);
      chk("addr_unc", 32'(bus_unc), 32'(t.unc));
      if (stall) scnt++;
      @(negedge clk);
    end
    addr_ok = 1'b0;
    for (int i = 0; i <= t.ddly; i++) begin
      data_ok = (i == t.ddly);
      brdata = data_ok ? t.brdata : 32'h5A5A5A5A;
      #1;
      chk("data_req", 32'(bus_req), 32'd0);
      if (stall) scnt++;
      @(negedge clk);
    end
    data_ok = 1'b0; flush = 1'b0; brdata = 32'h0;
    #1;
    chk("rdata", rdata, t.rdata);
    chk("stall_cycles", 32'(scnt), 32'(2 + t.adly + t.ddly));
    chk("idle_stall", 32'(stall), 32'd0);
  endtask

  initial begin
    v[0]  = '{4'h0, 4'd1, 1'b0, 32'h1FC00003, 32'h0, 32'h80FFFF7F, 0, 0, 2'd0, 32'hFFFFFF80};
    v[1]  = '{4'h0, 4'd4, 1'b0, 32'h00000002, 32'h0, 32'h80011234, 0, 0, 2'd1, 32'h00008001};
    v[2]  = '{4'hF, 4'd0, 1'b1, 32'h00000100, 32'hDEADBEEF, 32'h0BADF00D, 4, 0, 2'd2, 32'h00008001};
    v[3]  = '{4'h0, 4'd0, 1'b1, 32'h00001004, 32'h0, 32'h12345678, 0, 1, 2'd2, 32'h12345678};
    v[4]  = '{4'h0, 4'd2, 1'b0, 32'h00000001, 32'h0, 32'h0000A500, 0, 0, 2'd0, 32'h000000A5};
    v[5]  = '{4'h0, 4'd3, 1'b0, 32'h00000000, 32'h0, 32'h12348765, 0, 0, 2'd1, 32'hFFFF8765};
    v[6]  = '{4'h4, 4'd0, 1'b0, 32'h00000202, 32'h00AB0000, 32'h0BADF00D, 0, 0, 2'd0, 32'hFFFF8765};
    v[7]  = '{4'hC, 4'd0, 1'b0, 32'h00000302, 32'h55660000, 32'h0BADF00D, 1, 0, 2'd1, 32'hFFFF8765};
    v[8]  = '{4'h0, 4'd7, 1'b0, 32'h00000008, 32'h0, 32'hCAFEF00D, 0, 2, 2'd2, 32'hCAFEF00D};
    v[9]  = '{4'h7, 4'd0, 1'b0, 32'h00000010, 32'h00112233, 32'h0BADF00D, 0, 0, 2'd2, 32'hCAFEF00D};
    v[10] = '{4'h0, 4'd1, 1'b0, 32'h00000001, 32'h0, 32'h00007F00, 0, 0, 2'd0, 32'h0000007F};
    v[11] = '{4'h0, 4'd3, 1'b0, 32'h00000002, 32'h0, 32'h9ABC0000, 0, 0, 2'd1, 32'hFFFF9ABC};

    resetn = 1'b0; ena = 1'b0; wen = 4'h0; lt = 4'h0; unc = 1'b0;
    vaddr = 32'h0; psy = 32'h0; wdata = 32'h0; flush = 1'b0;
    addr_ok = 1'b0; data_ok = 1'b0; brdata = 32'h0;

    repeat (2) @(negedge clk);
    #1 chk_idle_outputs("rst");
    chk("rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    ena = 1'b1;
    #1 chk("post_rst_stall", 32'(stall), 32'd1);
    ena = 1'b0;
    #1 chk("post_rst_nostall", 32'(stall), 32'd0);

    for (int i = 0; i < 12; i++) run(v[i], 1'b0);

    // flush in IDLE: nothing accepted
    @(negedge clk);
    ena = 1'b1; flush = 1'b1; psy = 32'h00000444; wen = 4'h0; lt = 4'd0;
    #1 chk("flush_idle_stall", 32'(stall), 32'd0);
    @(negedge clk);
    #1 chk("flush_idle_req", 32'(bus_req), 32'd0);
    chk("flush_idle_stall2", 32'(stall), 32'd0);
    ena = 1'b0; flush = 1'b0;

    // flush while in ADDR/DATA: transaction still completes
    run('{4'h0, 4'd2, 1'b0, 32'h00000003, 32'h0, 32'h7E000000, 1, 1, 2'd0, 32'h0000007E}, 1'b1);

    // reset while in DATA
    @(negedge clk);
    ena = 1'b1; wen = 4'h0; lt = 4'd0; psy = 32'h00000040;
    @(negedge clk);
    ena = 1'b0; addr_ok = 1'b1;
    @(negedge clk);
    addr_ok = 1'b0;
    #1 chk("pre_rst_data_stall", 32'(stall), 32'd1);
    resetn = 1'b0;
    #1 chk_idle_outputs("rst_data");
    chk("rst_data_stall", 32'(stall), 32'd0);
    @(negedge clk);
    resetn = 1'b1; data_ok = 1'b1; brdata = 32'hFFFFFFFF;
    #1 chk("stray_ok_stall", 32'(stall), 32'd0);
    @(negedge clk);
    data_ok = 1'b0;
    #1 chk("stray_ok_rdata", rdata, 32'd0);
    chk("stray_ok_req", 32'(bus_req), 32'd0);
    chk("stray_ok_idle", 32'(stall), 32'd0);

    // back-to-back loads with ena held high
    @(negedge clk);
    ena = 1'b1; wen = 4'h0; lt = 4'd1; psy = 32'h1FC00003;
    @(negedge clk);
    addr_ok = 1'b1;
    #1 chk("b2b_req1", 32'(bus_req), 32'd1);
    @(negedge clk);
    addr_ok = 1'b0; data_ok = 1'b1; brdata = 32'h80FFFF7F;
    lt = 4'd4; psy = 32'h00000002;
    #1 chk("b2b_ok_stall", 32'(stall), 32'd0);
    @(negedge clk);
    data_ok = 1'b0;
    #1 chk("b2b_rdata1", rdata, 32'hFFFFFF80);
    chk("b2b_idle_req", 32'(bus_req), 32'd0);
    chk("b2b_idle_stall", 32'(stall), 32'd1);
    @(negedge clk);
    ena = 1'b0;
    #1 chk("b2b_req2", 32'(bus_req), 32'd1);
    chk("b2b_size2", 32'(bus_size), 32'd1);
    chk("b2b_addr2", bus_addr, 32'h00000002);
    addr_ok = 1'b1;
    @(negedge clk);
    addr_ok = 1'b0; data_ok = 1'b1; brdata = 32'h80011234;
    @(negedge clk);
    data_ok = 1'b0;
    #1 chk("b2b_rdata2", rdata, 32'h00008001);
    chk("b2b_end_stall", 32'(stall), 32'd0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
